// File: rtl/stream_capture_mon.sv
// rtl/stream_capture_mon.sv - per-channel write counters/checksums with serial nibble dump
//
// Ports:
//   ap_clk      - single clock, all state on rising edge
//   ap_rst_n    - asynchronous active-low reset
//   ch_write    - per-channel write strobes (bit c = stream c)
//   ch_din      - per-channel data, stream c in [c*DATA_W +: DATA_W]
//   clear       - zeroes live counters and checksums (wins over same-cycle writes)
//   dump_req    - snapshot live statistics and start a serial dump
//   data_out    - dump nibble (0 when not valid)
//   data_valid  - data_out holds a frame nibble
//   busy        - dump frame in progress
//
// Frame: 4'hA, then for each channel cnt (MSB nibble first) and chk
// (MSB nibble first), then 4'h5, with no gaps.

module stream_capture_mon #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*DATA_W-1:0] ch_din,
    input  logic                     clear,
    input  logic                     dump_req,
    output logic [3:0]               data_out,
    output logic                     data_valid,
    output logic                     busy
);

    localparam int CNT_NIB  = CNT_W / 4;
    localparam int DATA_NIB = DATA_W / 4;
    localparam int NIB_MAX  = (CNT_NIB > DATA_NIB) ? CNT_NIB : DATA_NIB;
    localparam int NIB_W    = (NIB_MAX > 1) ? $clog2(NIB_MAX) : 1;
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        CNT  = 3'd2,
        CHK  = 3'd3,
        TRL  = 3'd4
    } state_t;

    state_t             state;
    state_t             nxt_state;
    logic [CH_W-1:0]    ch;
    logic [CH_W-1:0]    nxt_ch;
    logic [NIB_W-1:0]   nib;
    logic [NIB_W-1:0]   nxt_nib;
    logic               capture;

    logic [CNT_W-1:0]   cnt      [NUM_CH];
    logic [DATA_W-1:0]  chk      [NUM_CH];
    logic [CNT_W-1:0]   snap_cnt [NUM_CH];
    logic [DATA_W-1:0]  snap_chk [NUM_CH];

    logic [3:0]         nxt_data;
    logic               nxt_valid;
    logic [CNT_W-1:0]   cnt_word;
    logic [DATA_W-1:0]  chk_word;

    // Live statistics: touched only by clear and writes, never by the dump.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt[c] <= '0;
                chk[c] <= '0;
            end
        end else if (clear) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt[c] <= '0;
                chk[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_write[c]) begin
                    if (cnt[c] != {CNT_W{1'b1}}) begin
                        cnt[c] <= cnt[c] + CNT_W'(1);
                    end
                    chk[c] <= {chk[c][DATA_W-2:0], chk[c][DATA_W-1]}
                              ^ ch_din[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Snapshot takes the pre-edge live values, so a write on the dump_req
    // edge shows up live but not in this frame.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                snap_cnt[c] <= '0;
                snap_chk[c] <= '0;
            end
        end else if (capture) begin
            for (int c = 0; c < NUM_CH; c++) begin
                snap_cnt[c] <= cnt[c];
                snap_chk[c] <= chk[c];
            end
        end
    end

    // FSM state register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
            ch    <= '0;
            nib   <= '0;
        end else begin
            state <= nxt_state;
            ch    <= nxt_ch;
            nib   <= nxt_nib;
        end
    end

    // FSM next-state logic
    always_comb begin
        nxt_state = state;
        nxt_ch    = ch;
        nxt_nib   = nib;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (dump_req) begin
                    nxt_state = HDR;
                    capture   = 1'b1;
                end
            end
            HDR: begin
                nxt_state = CNT;
                nxt_ch    = '0;
                nxt_nib   = '0;
            end
            CNT: begin
                if (nib == NIB_W'(CNT_NIB - 1)) begin
                    nxt_state = CHK;
                    nxt_nib   = '0;
                end else begin
                    nxt_nib = nib + NIB_W'(1);
                end
            end
            CHK: begin
                if (nib == NIB_W'(DATA_NIB - 1)) begin
                    nxt_nib = '0;
                    if (ch == CH_W'(NUM_CH - 1)) begin
                        nxt_state = TRL;
                    end else begin
                        nxt_state = CNT;
                        nxt_ch    = ch + CH_W'(1);
                    end
                end else begin
                    nxt_nib = nib + NIB_W'(1);
                end
            end
            TRL: begin
                nxt_state = IDLE;
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // FSM output logic: the nibble for the state being entered is computed
    // here and registered below, so the header appears the cycle right
    // after dump_req is sampled.
    always_comb begin
        nxt_data  = 4'h0;
        nxt_valid = (nxt_state != IDLE);
        cnt_word  = '0;
        chk_word  = '0;
        case (nxt_state)
            HDR: nxt_data = 4'hA;
            CNT: begin
                cnt_word = snap_cnt[nxt_ch] >> (4 * (CNT_NIB - 1 - int'(nxt_nib)));
                nxt_data = cnt_word[3:0];
            end
            CHK: begin
                chk_word = snap_chk[nxt_ch] >> (4 * (DATA_NIB - 1 - int'(nxt_nib)));
                nxt_data = chk_word[3:0];
            end
            TRL: nxt_data = 4'h5;
            default: nxt_data = 4'h0;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            data_out   <= 4'h0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_out   <= nxt_data;
            data_valid <= nxt_valid;
            busy       <= nxt_valid;
        end
    end

endmodule

// File: tb/tb_stream_capture_mon.sv
// tb/tb_stream_capture_mon.sv - scoreboard bench for stream_capture_mon

module tb_stream_capture_mon;

    localparam int NC    = 8;
    localparam int DW    = 32;
    localparam int CW    = 32;
    localparam int FRAME = 2 + NC * (CW + DW) / 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NC-1:0]     ch_write;
    logic [NC*DW-1:0]  ch_din;
    logic              clear;
    logic              dump_req;
    logic [3:0]        data_out;
    logic              data_valid;
    logic              busy;

    logic [1:0]        s_write;
    logic [15:0]       s_din;
    logic              s_clear;
    logic              s_dump;
    logic [3:0]        s_data;
    logic              s_valid;
    logic              s_busy;

    always #5 clk = ~clk;

    stream_capture_mon #(.NUM_CH(NC), .DATA_W(DW), .CNT_W(CW)) dut (
        .ap_clk     (clk),
        .ap_rst_n   (rst_n),
        .ch_write   (ch_write),
        .ch_din     (ch_din),
        .clear      (clear),
        .dump_req   (dump_req),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy)
    );

    stream_capture_mon #(.NUM_CH(2), .DATA_W(8), .CNT_W(4)) dut_sat (
        .ap_clk     (clk),
        .ap_rst_n   (rst_n),
        .ch_write   (s_write),
        .ch_din     (s_din),
        .clear      (s_clear),
        .dump_req   (s_dump),
        .data_out   (s_data),
        .data_valid (s_valid),
        .busy       (s_busy)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int valid_cycles = 0;

    logic [CW-1:0] m_cnt [NC];
    logic [DW-1:0] m_chk [NC];
    logic [3:0]    exp_q [$];
    bit            m_prev_valid;

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_cnt[c] = '0;
            m_chk[c] = '0;
        end
        exp_q.delete();
        m_prev_valid = 1'b0;
    endtask

    task automatic push_frame();
        exp_q.push_back(4'hA);
        for (int c = 0; c < NC; c++) begin
            for (int n = 0; n < CW / 4; n++) exp_q.push_back(4'(m_cnt[c] >> (CW - 4 - 4 * n)));
            for (int n = 0; n < DW / 4; n++) exp_q.push_back(4'(m_chk[c] >> (DW - 4 - 4 * n)));
        end
        exp_q.push_back(4'h5);
    endtask

    // One clock of stimulus; the scoreboard predicts at the edge and the
    // observed outputs are compared half a cycle later.
    task automatic tick(input logic [NC-1:0] wr, input logic [NC*DW-1:0] din,
                        input logic clr, input logic dreq);
        logic       exp_v;
        logic [3:0] exp_d;
        ch_write = wr;
        ch_din   = din;
        clear    = clr;
        dump_req = dreq;
        @(posedge clk);
        if (dreq && !m_prev_valid) push_frame();
        if (clr) begin
            for (int c = 0; c < NC; c++) begin
                m_cnt[c] = '0;
                m_chk[c] = '0;
            end
        end else begin
            for (int c = 0; c < NC; c++) begin
                if (wr[c]) begin
                    if (m_cnt[c] != {CW{1'b1}}) m_cnt[c] = m_cnt[c] + 1;
                    m_chk[c] = {m_chk[c][DW-2:0], m_chk[c][DW-1]} ^ din[c*DW +: DW];
                end
            end
        end
        @(negedge clk);
        ch_write = '0;
        ch_din   = '0;
        clear    = 1'b0;
        dump_req = 1'b0;
        exp_v = (exp_q.size() != 0);
        exp_d = exp_v ? exp_q.pop_front() : 4'h0;
        m_prev_valid = exp_v;
        if (data_valid === 1'b1) valid_cycles++;
        total_cnt++;
        if (data_valid !== exp_v) $display("FAIL data_valid: got %b want %b", data_valid, exp_v);
        else pass_cnt++;
        total_cnt++;
        if (busy !== exp_v) $display("FAIL busy: got %b want %b", busy, exp_v);
        else pass_cnt++;
        total_cnt++;
        if (data_out !== exp_d) $display("FAIL data_out: got %h want %h", data_out, exp_d);
        else pass_cnt++;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            tick('0, '0, 1'b0, 1'b0);
            guard++;
        end
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL %s drain timeout: %0d nibbles left, want 0", name, exp_q.size());
        else pass_cnt++;
        tick('0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ch_write = '0; ch_din = '0; clear = 1'b0; dump_req = 1'b0;
        s_write = '0; s_din = '0; s_clear = 1'b0; s_dump = 1'b0;
        model_reset();
        #1;
        total_cnt++;
        if ({data_out, data_valid, busy} !== 6'b0) $display("FAIL reset outputs: got %b want 000000", {data_out, data_valid, busy});
        else pass_cnt++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick('0, '0, 1'b0, 1'b0);
        valid_cycles = 0;
        tick('0, '0, 1'b0, 1'b1);
        drain("reset_frame");
        total_cnt++;
        if (valid_cycles != FRAME) $display("FAIL frame_length: got %0d want %0d", valid_cycles, FRAME);
        else pass_cnt++;
    endtask

    task automatic test_ch0_pattern();
        logic [NC*DW-1:0] d;
        d = '0; d[31:0] = 32'h1; tick(8'h01, d, 1'b0, 1'b0);
        d = '0; d[31:0] = 32'h2; tick(8'h01, d, 1'b0, 1'b0);
        d = '0; d[31:0] = 32'h4; tick(8'h01, d, 1'b0, 1'b0);
        tick('0, '0, 1'b0, 1'b1);
        drain("ch0_pattern");
    endtask

    task automatic test_all_ch();
        tick('0, '0, 1'b1, 1'b0);
        tick({NC{1'b1}}, {NC*DW{1'b1}}, 1'b0, 1'b0);
        tick('0, '0, 1'b0, 1'b1);
        drain("all_ch");
    endtask

    task automatic test_dump_overlap();
        logic [NC*DW-1:0] d;
        tick('0, '0, 1'b1, 1'b0);
        d = '0; d[3*DW +: DW] = 32'h1234_5678;
        tick(8'h08, d, 1'b0, 1'b1);
        for (int i = 0; i < 140; i++) begin
            d = '0;
            if (i == 60) begin
                d[2*DW +: DW] = 32'hDEAD_BEEF;
                tick(8'h04, d, 1'b1, 1'b0);
            end else if (i == 70) begin
                d[5*DW +: DW] = 32'h0000_A5A5;
                tick(8'h20, d, 1'b0, 1'b0);
            end else begin
                tick('0, '0, 1'b0, i == 20);
            end
        end
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL overlap_frame_end: got %0d left want 0", exp_q.size());
        else pass_cnt++;
        tick('0, '0, 1'b0, 1'b1);
        drain("overlap_second");
    endtask

    task automatic test_back_to_back();
        logic [NC*DW-1:0] d;
        tick('0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 2 * FRAME + 1; i++) begin
            d = '0;
            d[1*DW +: DW] = $urandom;
            tick(8'h02, d, 1'b0, 1'b1);
        end
        drain("back_to_back");
    endtask

    task automatic test_reset_mid_frame();
        tick('0, '0, 1'b0, 1'b1);
        repeat (49) tick('0, '0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({data_out, data_valid, busy} !== 6'b0) $display("FAIL mid_frame_reset: got %b want 000000", {data_out, data_valid, busy});
        else pass_cnt++;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick('0, '0, 1'b0, 1'b0);
        tick('0, '0, 1'b0, 1'b1);
        drain("post_reset_frame");
    endtask

    task automatic collect_sat(input logic [3:0] e [8], input string name);
        int k = 0;
        for (int g = 0; g < 20; g++) begin
            if (s_valid === 1'b1) begin
                total_cnt++;
                if (k < 8 && s_data === e[k]) pass_cnt++;
                else $display("FAIL %s nibble %0d: got %h want %h", name, k, s_data, (k < 8) ? e[k] : 4'hx);
                k++;
            end
            @(negedge clk);
        end
        total_cnt++;
        if (k != 8) $display("FAIL %s length: got %0d want 8", name, k);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        logic [3:0] sc;
        logic [7:0] sk;
        logic [7:0] v;
        logic [3:0] e [8];
        sc = '0; sk = '0;
        @(negedge clk);
        s_clear = 1'b1;
        @(negedge clk);
        s_clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            v = 8'($urandom);
            s_write = 2'b10;
            s_din = {v, 8'h00};
            if (sc != 4'hF) sc = sc + 4'd1;
            sk = {sk[6:0], sk[7]} ^ v;
            @(negedge clk);
        end
        s_write = '0; s_din = '0;
        s_dump = 1'b1;
        @(negedge clk);
        s_dump = 1'b0;
        e = '{4'hA, 4'h0, 4'h0, 4'h0, 4'hF, sk[7:4], sk[3:0], 4'h5};
        collect_sat(e, "sat_frame");
        s_clear = 1'b1;
        s_write = 2'b10;
        s_din = 16'hFF00;
        @(negedge clk);
        s_clear = 1'b0; s_write = '0; s_din = '0;
        s_dump = 1'b1;
        @(negedge clk);
        s_dump = 1'b0;
        e = '{4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h5};
        collect_sat(e, "clear_frame");
    endtask

    initial begin
        test_reset();
        test_ch0_pattern();
        test_all_ch();
        test_dump_overlap();
        test_back_to_back();
        test_reset_mid_frame();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/stream_capture_mon.md
STREAM_CAPTURE_MON -- requirements
Module: stream_capture_mon

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of monitored output streams (legal 1..16).
REQ-002 SHALL have parameter DATA_W, default 32: stream data width (multiple of 4).
REQ-003 SHALL have parameter CNT_W, default 32: per-channel write-counter width (multiple of 4).
REQ-004 SHALL have port ap_clk, input, 1: single clock; all state rising-edge.
REQ-005 SHALL have port ap_rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port ch_write, input, NUM_CH: bit c is the write strobe of stream c.
REQ-007 SHALL have port ch_din, input, NUM_CH*DATA_W: stream c data in bits [c*DATA_W +: DATA_W].
REQ-008 SHALL have port clear, input, 1: zeroes all live counters and checksums.
REQ-009 SHALL have port dump_req, input, 1: requests a serial dump of a statistics snapshot.
REQ-010 SHALL have port data_out, output, 4: serial dump nibble.
REQ-011 SHALL have port data_valid, output, 1: data_out holds a valid nibble.
REQ-012 SHALL have port busy, output, 1: dump in progress.

Function
REQ-013 Per channel c: live count cnt[c] SHALL increment by 1 on each sampled ch_write[c], saturating at all-ones with no wrap.
REQ-014 Per channel c: live checksum chk[c] SHALL update on each sampled write as chk = rotl1(chk) XOR din, where rotl1 is a 1-bit left rotate over DATA_W.
REQ-015 Updates SHALL be visible one cycle after the strobe, and all channels SHALL update independently in the same cycle.
REQ-016 clear SHALL take priority: cnt and chk go to 0, and writes sampled in the same cycle are discarded.
REQ-017 FSM states SHALL be IDLE, HDR, CNT, CHK, TRL.
REQ-018 IDLE: dump_req=1 SHALL copy every live cnt/chk value into a snapshot and go to HDR.
REQ-019 The snapshot SHALL hold the pre-edge values, so a write sampled on the dump_req edge is excluded from it but counted live.
REQ-020 HDR SHALL emit nibble 4'hA for 1 cycle, then go to CNT with channel index 0.
REQ-021 CNT SHALL emit snapshot cnt[ch] MSB-nibble first over CNT_W/4 cycles, then go to CHK.
REQ-022 CHK SHALL emit snapshot chk[ch] MSB-nibble first over DATA_W/4 cycles.
REQ-023 After CHK, the FSM SHALL go to CNT with ch+1 if ch<NUM_CH-1, else to TRL.
REQ-024 TRL SHALL emit 4'h5 for 1 cycle, then go to IDLE.
REQ-025 data_out and data_valid SHALL be registered, with the first nibble (4'hA) valid the cycle after dump_req is sampled.
REQ-026 A frame SHALL last exactly 2+NUM_CH*(CNT_W+DATA_W)/4 consecutive valid cycles (130 at defaults), with no gaps.
REQ-027 busy SHALL be high from the cycle after dump_req until the cycle after the trailer; data_valid SHALL be high in exactly the same cycles.
REQ-028 dump_req while busy SHALL be ignored (not queued).
REQ-029 clear and writes during a dump SHALL modify only live state, never the snapshot or the frame in progress.
REQ-030 When data_valid=0, data_out SHALL be 4'h0.

Reset
REQ-031 ap_rst_n=0 SHALL immediately (asynchronously) set the FSM to IDLE and all cnt, chk, snapshots and channel index to 0.
REQ-032 ap_rst_n=0 SHALL immediately drive data_out=0, data_valid=0 and busy=0.
REQ-033 Reset mid-frame SHALL abort the frame with no further valid nibbles, and a dump_req after reset release SHALL start a fresh frame reporting all-zero statistics.

Verification
REQ-034 After reset, pulse dump_req (defaults) -> 130 valid cycles: 4'hA, then 128 nibbles of 0, then 4'h5; busy matches data_valid.
REQ-035 Ch0 writes 0x00000001, 0x00000002, 0x00000004, then dump -> ch0 cnt=0x00000003, chk=0x00000004; other channels 0.
REQ-036 All 8 channels write 0xFFFFFFFF in the same cycle, then dump -> every channel cnt=1, chk=0xFFFFFFFF.
REQ-037 dump_req asserted in the same cycle as a ch3 write, a second dump_req mid-frame, and clear mid-frame -> first frame shows ch3 cnt=0, second dump_req ignored, frame unaffected by clear; next dump shows post-clear live values.
REQ-038 CNT_W=4: 20 writes on ch1 -> cnt=4'hF (saturated); clear together with a write -> cnt=0, chk=0.
REQ-039 Assert ap_rst_n=0 at frame nibble 50 -> data_valid/busy low in the same cycle; a dump after release gives an all-zero frame.
